// File: rtl/i2s_transmitter_if.sv
// ---------------------------------------------------------------------------
// i2s_transmitter_if
//
// Sample-side handshake bundle for i2s_transmitter. One transfer moves a
// stereo pair and happens on a rising clk_in edge where valid_in && ready_out.
//
// Signals:
//   left_in   [DATA_WIDTH]  left sample, two's complement
//   right_in  [DATA_WIDTH]  right sample, two's complement
//   valid_in                source offers a pair
//   ready_out               transmitter holding register is empty
//
// Modports:
//   master - sample source (drives samples and valid_in)
//   slave  - i2s_transmitter (drives ready_out)
// ---------------------------------------------------------------------------
interface i2s_transmitter_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] left_in;
  logic [DATA_WIDTH-1:0] right_in;
  logic                  valid_in;
  logic                  ready_out;

  modport master (
    output left_in,
    output right_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  left_in,
    input  right_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/i2s_transmitter.sv
// ---------------------------------------------------------------------------
// i2s_transmitter
//
// Philips I2S serialiser. Stereo pairs arrive over a valid/ready handshake
// into a single-pair holding register, and are moved into a 64-bit frame
// shift register at the start of every frame. A frame is 64 sclk periods:
// left sample MSB-first in slots k=0..DATA_WIDTH-1, right sample in slots
// k=32..31+DATA_WIDTH, zeros elsewhere. ws is high for k=31..62 so it leads
// each channel's MSB by one bit clock. sdata/ws change only on sclk falling
// edges.
//
// Parameters:
//   DATA_WIDTH  sample width per channel, 8..32
//   SCLK_DIV    clk_in cycles per sclk half-period, >= 2
//
// Ports:
//   clk_in        system clock, rising edge
//   rst_in        asynchronous, active-high reset
//   smp           slave side of i2s_transmitter_if (samples, valid, ready)
//   sclk_out      I2S bit clock
//   ws_out        word select, 0 = left, 1 = right
//   sdata_out     I2S serial data, MSB first
//   underrun_out  one-cycle pulse when a frame starts with no pair waiting
//
// Build option:
//   I2S_TX_HOLD_LAST_EN  when defined, a starved frame repeats the most
//                        recently loaded pair; otherwise it sends zeros.
// ---------------------------------------------------------------------------
module i2s_transmitter #(
  parameter int DATA_WIDTH = 24,
  parameter int SCLK_DIV   = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  i2s_transmitter_if.slave   smp,
  output logic               sclk_out,
  output logic               ws_out,
  output logic               sdata_out,
  output logic               underrun_out
);

  localparam int                DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam int                PAD      = 32 - DATA_WIDTH;

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_FULL
  } hold_state_t;

  // Sample placed left-justified in its 32-bit half-frame slot.
  function automatic logic [31:0] slot(input logic [DATA_WIDTH-1:0] s);
    slot = 32'(s) << PAD;
  endfunction

  logic [DIV_W-1:0]      div_cnt;
  logic [5:0]            bit_idx;
  logic [5:0]            bit_next;
  logic                  sclk_fall;
  logic                  frame_load;
  logic                  accept;

  hold_state_t           hold_state;
  logic [DATA_WIDTH-1:0] hold_left;
  logic [DATA_WIDTH-1:0] hold_right;

  logic [DATA_WIDTH-1:0] load_left;
  logic [DATA_WIDTH-1:0] load_right;
  logic [63:0]           load_frame;
  logic [63:0]           shift_reg;

  // -------------------------------------------------------------------------
  // Bit clock generation
  // -------------------------------------------------------------------------
  // sclk_fall marks the clk_in cycle whose closing edge drives sclk low;
  // all frame-side state advances on that edge.
  assign sclk_fall  = (div_cnt == DIV_LAST) && sclk_out;
  assign frame_load = sclk_fall && (bit_idx == 6'd63);
  assign bit_next   = bit_idx + 6'd1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt  <= '0;
      sclk_out <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      sclk_out <= ~sclk_out;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // Bit index starts at 63 so the first falling edge after reset enters
  // k=0 and performs a frame load.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bit_idx <= 6'd63;
    end else if (sclk_fall) begin
      bit_idx <= bit_next;
    end
  end

  // -------------------------------------------------------------------------
  // Holding register
  // -------------------------------------------------------------------------
  assign smp.ready_out = (hold_state == HOLD_EMPTY);
  assign accept        = smp.valid_in && (hold_state == HOLD_EMPTY);

  // An accept coinciding with a load while empty is not bypassed: the load
  // sees the old (empty) state, and the new pair waits for the next frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hold_state <= HOLD_EMPTY;
      hold_left  <= '0;
      hold_right <= '0;
    end else begin
      case (hold_state)
        HOLD_EMPTY: begin
          if (accept) begin
            hold_left  <= smp.left_in;
            hold_right <= smp.right_in;
            hold_state <= HOLD_FULL;
          end
        end
        HOLD_FULL: begin
          if (frame_load) begin
            hold_state <= HOLD_EMPTY;
          end
        end
        default: hold_state <= HOLD_EMPTY;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Frame source selection
  // -------------------------------------------------------------------------
`ifdef I2S_TX_HOLD_LAST_EN
  logic [DATA_WIDTH-1:0] last_left;
  logic [DATA_WIDTH-1:0] last_right;

  // Tracks only pairs that came from the holding register; a repeated frame
  // does not refresh it, so it always holds the most recent real pair.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_left  <= '0;
      last_right <= '0;
    end else if (frame_load && (hold_state == HOLD_FULL)) begin
      last_left  <= hold_left;
      last_right <= hold_right;
    end
  end

  always_comb begin
    load_left  = last_left;
    load_right = last_right;
    if (hold_state == HOLD_FULL) begin
      load_left  = hold_left;
      load_right = hold_right;
    end
  end
`else
  always_comb begin
    load_left  = '0;
    load_right = '0;
    if (hold_state == HOLD_FULL) begin
      load_left  = hold_left;
      load_right = hold_right;
    end
  end
`endif

  assign load_frame = {slot(load_left), slot(load_right)};

  // -------------------------------------------------------------------------
  // Serialiser and registered outputs
  // -------------------------------------------------------------------------
  // On a load, bit 63 of the new frame goes straight to sdata_out and the
  // remaining 63 bits are parked in shift_reg, so the MSB appears on the
  // load edge itself rather than one bit clock later.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_reg <= '0;
      sdata_out <= 1'b0;
      ws_out    <= 1'b0;
    end else if (sclk_fall) begin
      ws_out <= (bit_next >= 6'd31) && (bit_next <= 6'd62);
      if (frame_load) begin
        sdata_out <= load_frame[63];
        shift_reg <= {load_frame[62:0], 1'b0};
      end else begin
        sdata_out <= shift_reg[63];
        shift_reg <= {shift_reg[62:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      underrun_out <= 1'b0;
    end else begin
      underrun_out <= frame_load && (hold_state == HOLD_EMPTY);
    end
  end

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 Parameter DATA_WIDTH, default 24, meaning sample width per channel; the legal range SHALL be 8..32.
REQ-002 Parameter SCLK_DIV, default 16, meaning clk_in cycles per sclk half-period; the legal range SHALL be >=2.
REQ-003 clk_in  input  1  meaning the single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_in  input  1  meaning reset; it SHALL be asynchronous and active-high.
REQ-005 left_in  input  DATA_WIDTH  meaning the left sample, two's complement; it SHALL be captured on accept.
REQ-006 right_in  input  DATA_WIDTH  meaning the right sample, two's complement; it SHALL be captured on accept.
REQ-007 valid_in  input  1  meaning a stereo pair is offered.
REQ-008 ready_out  output  1  meaning the holding register is empty; an accept SHALL occur when valid_in && ready_out.
REQ-009 sclk_out  output  1  meaning the I2S bit clock.
REQ-010 ws_out  output  1  meaning word select; 0 SHALL mean left and 1 SHALL mean right.
REQ-011 sdata_out  output  1  meaning I2S serial data, MSB first.
REQ-012 underrun_out  output  1  meaning a one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-013 The frame format SHALL be 64 sclk periods, indexed by bit index k = 0..63, with k advancing on every sclk falling edge.
REQ-014 sclk_out SHALL toggle every SCLK_DIV clk_in cycles, giving a period of 2*SCLK_DIV cycles.
REQ-015 ws_out SHALL be 1 for k = 31..62 and 0 otherwise, so ws leads its channel's MSB by one sclk period.
REQ-016 For k = 0..DATA_WIDTH-1, sdata_out SHALL equal left[DATA_WIDTH-1-k].
REQ-017 For k = 32..31+DATA_WIDTH, sdata_out SHALL equal right[DATA_WIDTH-1-(k-32)].
REQ-018 For all other k, sdata_out SHALL be 0.
REQ-019 sdata_out and ws_out SHALL change only in the clk_in cycle in which sclk_out falls, so they are stable across each rising edge.
REQ-020 The holding register SHALL be a single stereo pair; on accept it SHALL load and become full in the next cycle, and ready_out SHALL then drop.
REQ-021 Frame load SHALL occur on the sclk falling edge that enters k=0, and SHALL transfer the holding register to the shift register and mark it empty.
REQ-022 If the holding register is empty at frame load, underrun_out SHALL pulse high for exactly that one clk_in cycle, and the frame contents SHALL follow REQ-033 and REQ-034.
REQ-023 An accept in the same cycle as frame load with the register empty SHALL still count as an underrun; there SHALL be no bypass, and the accepted pair SHALL go out in the following frame.
REQ-024 When the register is full at load, the load SHALL empty it, and ready_out SHALL return high in the next cycle.
REQ-025 Latency: a pair accepted at least one cycle before a frame load SHALL appear with the left MSB on sdata_out starting at that load edge.
REQ-026 ready_out SHALL be a direct decode of the register-empty flag, with no combinational path from valid_in.
REQ-027 The counter SHALL wrap from k=63 to k=0 with no gap between frames.

Reset
REQ-028 While rst_in is high, outputs SHALL be: sclk_out=0, ws_out=0, sdata_out=0, underrun_out=0, ready_out=1.
REQ-029 Reset SHALL put k=63, clear the divider counter, empty the holding register, and zero the shift and last-pair registers.
REQ-030 The first sclk falling edge SHALL occur 2*SCLK_DIV cycles after reset release, entering k=0 and performing a frame load; underrun SHALL be flagged if nothing has been accepted by then.
REQ-031 Reset asserted mid-frame SHALL immediately force all outputs to their reset values and discard any pending pair.

Configuration
REQ-032 Macro I2S_TX_HOLD_LAST_EN SHALL select the underrun behaviour.
REQ-033 With I2S_TX_HOLD_LAST_EN defined, an underrun frame SHALL retransmit the most recently loaded pair (zeros if none since reset).
REQ-034 Without I2S_TX_HOLD_LAST_EN, an underrun frame SHALL transmit all zeros, and no last-pair register SHALL exist.
REQ-035 underrun_out behaviour SHALL be identical in both builds.

Verification (DATA_WIDTH=24, SCLK_DIV=2)
REQ-036 Scenario: reset, then accept left=24'hA5_0F3C and right=24'h5A_F0C3 before the first load -> sdata bits at k=0..23 SHALL equal 0xA50F3C MSB first, k=32..55 SHALL equal 0x5AF0C3, the rest 0, and no underrun.
REQ-037 Scenario: check ws timing -> ws SHALL rise at the k=31 falling edge and fall at k=63, and sdata/ws SHALL never change while sclk is high; the sclk period SHALL be 4 clk cycles.
REQ-038 Scenario: hold valid_in high continuously -> exactly one accept SHALL occur per frame (every 256 clk cycles), and ready_out SHALL be low between accept and load.
REQ-039 Scenario: supply one pair 24'h123456/24'h654321, then none -> the next frame SHALL repeat it with HOLD_LAST or be all zeros without, and underrun_out SHALL pulse once per starved frame.
REQ-040 Scenario: accept in the exact load cycle with the register empty -> underrun SHALL pulse, and the pair SHALL be transmitted in the following frame.
REQ-041 Scenario: assert rst_in at k=40 -> outputs SHALL reach reset values within the same cycle, and after release the first load SHALL be 4 cycles later.
